// File: rtl/vga_pkg.sv
// vga_pkg: timing constants shared with the VGA timing generator and pixel colour types
package vga_pkg;
  localparam int H_OFFSET = 160;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: strobe-enabled shift register aligning timing flags with the frame-buffer read
module vga_sync_delay #(
  parameter int DEPTH = 2,
  parameter int W = 5,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= INIT;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: maps VGA timing counters to a windowed, upscaled frame-buffer read and RGB444 output
module vga_frame_reader import vga_pkg::*; #(
  parameter int H_OFFSET = vga_pkg::H_OFFSET,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int SCALE = 1,
  parameter int WIN_X = 192,
  parameter int WIN_Y = 112,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_stb,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              active_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_en,
  input  logic [23:0]       fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_start
);
  localparam int P = 1 + RD_LAT;
  localparam int RW = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam logic [10:0] X_LO = 11'(H_OFFSET + WIN_X);
  localparam logic [10:0] X_HI = 11'(H_OFFSET + WIN_X + IMG_W * SCALE);
  localparam logic [10:0] Y_LO = 11'(WIN_Y);
  localparam logic [10:0] Y_HI = 11'(WIN_Y + IMG_H * SCALE);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_W * (IMG_H - 1));
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [RW-1:0] REP_LAST = RW'(SCALE - 1);
  logic [10:0] xe, ye;
  logic in_win, last_col, first_pix, unused_lsbs;
  logic [ADDR_W-1:0] row_base, col_idx;
  logic [RW-1:0] hrep, vrep;
  logic [4:0] flags_d;
  logic [11:0] rgb_next;
  rgb888_t px;
  rgb444_t rgb_q;
  assign xe = {1'b0, x_in};
  assign ye = {1'b0, y_in};
  assign in_win = active_in && xe >= X_LO && xe < X_HI && ye >= Y_LO && ye < Y_HI;
  assign last_col = in_win && xe == X_HI - 11'd1;
  assign first_pix = x_in == 10'(H_OFFSET) && y_in == '0;
  assign fb_en = pix_stb & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      row_base <= '0;
      col_idx <= '0;
      hrep <= '0;
      vrep <= '0;
      fb_addr <= '0;
    end else if (pix_stb) begin
      if (x_in == '0 && y_in == '0) begin
        row_base <= '0;
        vrep <= '0;
      end else if (last_col) begin
        vrep <= vrep == REP_LAST ? '0 : vrep + 1'b1;
        // saturate on the last image row so the address never leaves the image
        if (vrep == REP_LAST && row_base < ROW_MAX) row_base <= row_base + ROW_STEP;
      end
      if (!active_in || xe < X_LO) begin
        col_idx <= '0;
        hrep <= '0;
      end else if (in_win) begin
        hrep <= hrep == REP_LAST ? '0 : hrep + 1'b1;
        if (hrep == REP_LAST) col_idx <= col_idx + 1'b1;
        fb_addr <= row_base + col_idx;
      end
    end
  end
  // flags: {first_pix, active, in_win, hsync, vsync}; syncs idle high
  vga_sync_delay #(.DEPTH(P), .W(5), .INIT(5'b00011)) u_dly (
    .clk(clk),
    .reset(reset),
    .en(pix_stb),
    .d({first_pix, active_in, in_win, hsync_in, vsync_in}),
    .q(flags_d)
  );
  assign px = fb_data;
  assign unused_lsbs = ^{px.r[3:0], px.g[3:0], px.b[3:0]};
  always_comb rgb_next = !flags_d[3] ? 12'h000 : !flags_d[2] ? BORDER_COLOR : {px.r[7:4], px.g[7:4], px.b[7:4]};
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_stb & flags_d[4];
      if (pix_stb) begin
        rgb_q <= rgb_next;
        hsync_out <= flags_d[1];
        vsync_out <= flags_d[0];
      end
    end
  end
  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Pixel-stage consumer of the 640x480 VGA timing generator: turns raw h/v counters plus active/sync flags into a frame-buffer read stream and 12-bit RGB VGA output.
- Places an IMG_W x IMG_H image (integer upscaled by SCALE) at a fixed window in the active area; fills the rest of the active area with BORDER_COLOR.
- Delays hsync/vsync to match the read pipeline, so colour and sync leave the block aligned.

Parameters:
- H_OFFSET, 160, raw x count of first active column (active column ax = x_in - H_OFFSET)
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in lines
- SCALE, 1, pixel/line replication factor, 1 or 2
- WIN_X, 192, window left edge in active columns
- WIN_Y, 112, window top edge in lines
- ADDR_W, 16, frame-buffer address width; must cover IMG_W*IMG_H
- RD_LAT, 1, frame-buffer read latency in fb_en cycles, 1 or 2
- BORDER_COLOR, 12'h000, RGB444 fill colour for active pixels outside the window

Ports:
- clk  in  1  base clock
- reset  in  1  reset, synchronous, active-high
- pix_stb  in  1  pixel strobe; all state advances only when high
- x_in  in  10  raw horizontal count from timing generator
- y_in  in  10  raw vertical count from timing generator
- active_in  in  1  active-pixel flag from timing generator
- hsync_in  in  1  active-low horizontal sync
- vsync_in  in  1  active-low vertical sync
- fb_addr  out  ADDR_W  frame-buffer read address
- fb_en  out  1  frame-buffer read/output-register enable
- fb_data  in  24  RGB888 pixel, valid RD_LAT fb_en cycles after its address
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync
- frame_start  out  1  one-clk pulse when the first pixel of a frame leaves the output

Behaviour:
- Reset values: fb_addr=0, fb_en=0, RGB=0, hsync_out=1, vsync_out=1, frame_start=0; all counters and pipeline flags cleared. Reset mid-frame discards in-flight pixels.
- fb_en = pix_stb & ~reset. The read port runs on every strobe, including outside the window, so the pipeline never stalls.
- Window hit: in_win = active_in & ax in [WIN_X, WIN_X+IMG_W*SCALE) & y_in in [WIN_Y, WIN_Y+IMG_H*SCALE).
- Address generation is incremental; no multiplier.
  - row_base: 0 at frame start (strobe with x_in==0 and y_in==0).
  - On the last window column of a window line: vrep increments. When vrep==SCALE-1, row_base += IMG_W and vrep is cleared.
  - col_idx: cleared on any strobe with ax < WIN_X or active_in==0. Within the window, hrep counts 0..SCALE-1, and col_idx increments when hrep wraps.
  - fb_addr = row_base + col_idx, registered; value is don't-care when in_win==0.
- Pipeline depth: P = 1 + RD_LAT strobes.
  - in_win, active_in, hsync_in and vsync_in pass through a P-deep shift register advanced on pix_stb.
  - Output registers load on the strobe after the pipeline end, so total input-to-output latency is P+1 strobes for every signal.
- Colour select at output stage, using delayed flags:
  - blank (active==0): RGB=0
  - active and ~in_win: BORDER_COLOR
  - in_win: {fb_data[23:20], fb_data[15:12], fb_data[7:4]}
- frame_start: high for the single clk cycle in which the output stage loads the pixel originating from x_in==H_OFFSET, y_in==0.
- Between strobes, all outputs hold.
- active_in may extend past 640 columns; any such column is outside the window and gets BORDER_COLOR, never an out-of-range address.
- If row_base would exceed IMG_W*(IMG_H-1), it is not advanced further; it is cleared only at frame start.

Decomposition:
- Package vga_pkg holds:
  - timing constants shared with the timing generator: H_OFFSET, active width 640, active height 480
  - typedef rgb444_t (packed r,g,b 4 bits each)
  - typedef rgb888_t
- Natural sub-module: vga_sync_delay, a parameterised-depth, strobe-enabled shift register carrying {active, in_win, hsync, vsync}.

Test Plan:
- Reset mid-line: assert reset with x_in=300, y_in=50 -> next clk RGB=0, hsync_out=vsync_out=1, fb_en=0. After release, first window pixel still fetches addr 50-WIN_Y lines' worth of row_base, which is 0 since row_base stays 0 until the next frame start.
- Window corner: SCALE=1, memory addr=data pattern. Pixel (ax=192, y=112) -> fb_addr=0. (ax=447, y=112) -> 255. (ax=192, y=113) -> 256. (ax=447, y=367) -> 65535.
- Alignment: RD_LAT=1. Toggle hsync_in at x_in=16 -> hsync_out changes exactly 3 strobes later. Colour of pixel ax=192 appears on the same strobe as its delayed active flag.
- Border/blank: BORDER_COLOR=12'hF0F. ax=100, y=200 -> RGB=F,0,F. x_in=50 (blank) -> RGB=0. ax=640 (active_in high) -> F,0,F.
- SCALE=2, IMG_W=4, IMG_H=2, WIN_X=WIN_Y=0 -> addresses along line 0 are 0,0,1,1,2,2,3,3. Lines 0 and 1 are identical. Line 2 starts at 4. Line 4 and beyond is border.
- Frame wrap: run two full frames -> frame_start pulses once per frame, one clk wide, and row_base restarts at 0 on frame 2, so the first window pixel has addr 0.
